// File: rtl/fetch_ctrl_pkg.sv
// Shared widths, the prefetch entry type and the fetch-address legality check
// used by the instruction-fetch sequencer.
package fetch_ctrl_pkg;

    localparam int INS_W         = 32;
    localparam int ADDR_W        = 32;
    localparam int INS_BYTES     = 4;
    localparam int MEM_BYTES_DEF = 400;

    localparam logic [INS_W-1:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INS_W-1:0]  ins;
    } fetch_entry_t;

    // A fetch address is usable only if word aligned and the whole word lies inside memory.
    function automatic logic pc_legal(input logic [ADDR_W-1:0] pc,
                                      input logic [ADDR_W-1:0] last_pc);
        return (pc[1:0] == 2'b00) && (pc <= last_pc);
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Memory-address and decode-handshake bundle between the fetch sequencer (master)
// and the memory/decode side (slave).
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;

    logic [ADDR_W-1:0] MEM_ADDR;
    logic [INS_W-1:0]  MEM_INS;
    logic              REDIRECT;
    logic [ADDR_W-1:0] REDIRECT_PC;
    logic              OUT_VALID;
    logic              OUT_READY;
    logic [INS_W-1:0]  OUT_INS;
    logic [ADDR_W-1:0] OUT_PC;

    modport master (
        output MEM_ADDR,
        input  MEM_INS,
        input  REDIRECT,
        input  REDIRECT_PC,
        output OUT_VALID,
        input  OUT_READY,
        output OUT_INS,
        output OUT_PC
    );

    modport slave (
        input  MEM_ADDR,
        output MEM_INS,
        output REDIRECT,
        output REDIRECT_PC,
        input  OUT_VALID,
        output OUT_READY,
        input  OUT_INS,
        input  OUT_PC
    );

endinterface

// File: rtl/fetch_ctrl_queue.sv
// Prefetch FIFO of {PC, INS} entries; flush wins over push, and a pop on a full
// queue frees its slot for a push in the same cycle.
module fetch_ctrl_queue
    import fetch_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    fetch_entry_t     slot_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_push = push && !flush && (!full || pop);
    assign do_pop  = pop && !empty;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload slots carry no reset; occupancy alone decides what is visible.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic wr_en;
            assign wr_en = do_push && (wr_ptr_q == PTR_W'(gi));
            always_ff @(posedge clk) begin
                if (wr_en) slot_q[gi] <= din;
            end
        end
    endgenerate

    always_comb begin
        head = '{pc: '0, ins: NOP};
        if (!empty) head = slot_q[rd_ptr_q];
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, pushes fetched words into the prefetch
// queue, and handles redirects, range/alignment faults and the fetch counter.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int               MEM_BYTES = MEM_BYTES_DEF,
    parameter int               DEPTH     = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              EN,
    fetch_ctrl_if.master      bus,
    output logic              FAULT,
    output logic [31:0]       FETCH_COUNT
);

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_BYTES - INS_BYTES);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       fetch_count_q, fetch_count_d;
    logic              fault_q, fault_d;

    logic         pc_ok;
    logic         out_valid;
    logic         pop;
    logic         push;
    logic         q_full;
    logic         q_empty;
    fetch_entry_t q_head;
    fetch_entry_t q_din;

    assign pc_ok     = pc_legal(pc_q, LAST_PC);
    assign out_valid = RST_N && !q_empty;
    assign pop       = out_valid && bus.OUT_READY;
    assign push      = EN && !fault_q && !bus.REDIRECT && pc_ok && (!q_full || pop);
    assign q_din     = '{pc: pc_q, ins: bus.MEM_INS};

    // Redirect outranks everything except reset and re-evaluates FAULT from its target.
    always_comb begin
        pc_d          = pc_q;
        fault_d       = fault_q;
        fetch_count_d = fetch_count_q;
        if (bus.REDIRECT) begin
            pc_d    = bus.REDIRECT_PC;
            fault_d = !pc_legal(bus.REDIRECT_PC, LAST_PC);
        end else if (EN && !pc_ok) begin
            fault_d = 1'b1;
        end else if (push) begin
            pc_d          = pc_q + ADDR_W'(INS_BYTES);
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pc_q          <= RESET_PC;
            fault_q       <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            fault_q       <= fault_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    fetch_ctrl_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (push),
        .pop   (pop),
        .flush (bus.REDIRECT),
        .din   (q_din),
        .full  (q_full),
        .empty (q_empty),
        .head  (q_head)
    );

    assign bus.MEM_ADDR  = RST_N ? pc_q : RESET_PC;
    assign bus.OUT_VALID = out_valid;
    assign bus.OUT_INS   = out_valid ? q_head.ins : NOP;
    assign bus.OUT_PC    = out_valid ? q_head.pc : '0;
    assign FAULT         = fault_q;
    assign FETCH_COUNT   = fetch_count_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: memory word at byte address 4*k holds 32'hC0DE_0000 + k.
module tb_fetch_ctrl;

    logic        CLK;
    logic        RST_N;
    logic        EN;
    logic        FAULT;
    logic [31:0] FETCH_COUNT;

    fetch_ctrl_if bus ();

    fetch_ctrl #(
        .MEM_BYTES (400),
        .DEPTH     (2),
        .RESET_PC  (32'h0)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .EN          (EN),
        .bus         (bus.master),
        .FAULT       (FAULT),
        .FETCH_COUNT (FETCH_COUNT)
    );

    logic [31:0] imem [100];
    assign bus.MEM_INS = (bus.MEM_ADDR < 32'd400 && bus.MEM_ADDR[1:0] == 2'b00)
                         ? imem[bus.MEM_ADDR[8:2]] : 32'h0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int pass_cnt  = 0;
    int check_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        step(2);
        RST_N = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 100; i++) imem[i] = 32'hC0DE_0000 + 32'(i);
        RST_N           = 1'b0;
        EN              = 1'b1;
        bus.OUT_READY   = 1'b1;
        bus.REDIRECT    = 1'b0;
        bus.REDIRECT_PC = 32'h0;

        // 1: streaming after reset
        step(2);
        check("rst_valid", 32'(bus.OUT_VALID), 32'd0);
        check("rst_addr", bus.MEM_ADDR, 32'd0);
        check("rst_fault", 32'(FAULT), 32'd0);
        check("rst_count", FETCH_COUNT, 32'd0);
        RST_N = 1'b1;
        step(1);
        check("t1_pc0", bus.OUT_PC, 32'd0);
        check("t1_ins0", bus.OUT_INS, 32'hC0DE_0000);
        step(1);
        check("t1_pc4", bus.OUT_PC, 32'd4);
        check("t1_ins4", bus.OUT_INS, 32'hC0DE_0001);
        step(1);
        check("t1_pc8", bus.OUT_PC, 32'd8);
        step(1);
        check("t1_pc12", bus.OUT_PC, 32'd12);
        step(1);
        check("t1_pc16", bus.OUT_PC, 32'd16);
        step(1);
        check("t1_pc20", bus.OUT_PC, 32'd20);
        check("t1_ins20", bus.OUT_INS, 32'hC0DE_0005);
        check("t1_valid", 32'(bus.OUT_VALID), 32'd1);

        // 2: backpressure fills the queue, then full-rate drain
        bus.OUT_READY = 1'b0;
        do_reset();
        step(5);
        check("t2_addr_hold", bus.MEM_ADDR, 32'd8);
        check("t2_count", FETCH_COUNT, 32'd2);
        check("t2_head", bus.OUT_PC, 32'd0);
        bus.OUT_READY = 1'b1;
        step(1);
        check("t2_pc4", bus.OUT_PC, 32'd4);
        step(1);
        check("t2_pc8", bus.OUT_PC, 32'd8);
        check("t2_ins8", bus.OUT_INS, 32'hC0DE_0002);
        step(1);
        check("t2_pc12", bus.OUT_PC, 32'd12);
        step(1);
        check("t2_pc16", bus.OUT_PC, 32'd16);
        check("t2_count6", FETCH_COUNT, 32'd6);

        // 3: redirect coinciding with a pop of PC 8 while PC 12 is queued
        bus.OUT_READY = 1'b0;
        do_reset();
        step(2);
        bus.OUT_READY = 1'b1;
        step(2);
        check("t3_head8", bus.OUT_PC, 32'd8);
        check("t3_head8_valid", 32'(bus.OUT_VALID), 32'd1);
        bus.REDIRECT    = 1'b1;
        bus.REDIRECT_PC = 32'd40;
        step(1);
        bus.REDIRECT = 1'b0;
        check("t3_flush_valid", 32'(bus.OUT_VALID), 32'd0);
        check("t3_addr40", bus.MEM_ADDR, 32'd40);
        check("t3_count", FETCH_COUNT, 32'd4);
        step(1);
        check("t3_pc40", bus.OUT_PC, 32'd40);
        check("t3_ins40", bus.OUT_INS, 32'hC0DE_000A);

        // 4: misaligned redirect faults; a legal redirect recovers
        bus.REDIRECT    = 1'b1;
        bus.REDIRECT_PC = 32'd42;
        step(1);
        bus.REDIRECT = 1'b0;
        check("t4_fault", 32'(FAULT), 32'd1);
        check("t4_addr42", bus.MEM_ADDR, 32'd42);
        step(3);
        check("t4_fault_hold", 32'(FAULT), 32'd1);
        check("t4_no_push", FETCH_COUNT, 32'd5);
        check("t4_no_valid", 32'(bus.OUT_VALID), 32'd0);
        check("t4_addr_hold", bus.MEM_ADDR, 32'd42);
        bus.REDIRECT    = 1'b1;
        bus.REDIRECT_PC = 32'd16;
        step(1);
        bus.REDIRECT = 1'b0;
        check("t4_fault_clr", 32'(FAULT), 32'd0);
        check("t4_addr16", bus.MEM_ADDR, 32'd16);
        step(1);
        check("t4_pc16", bus.OUT_PC, 32'd16);
        check("t4_ins16", bus.OUT_INS, 32'hC0DE_0004);
        check("t4_count6", FETCH_COUNT, 32'd6);

        // 5: run off the end of memory
        bus.REDIRECT    = 1'b1;
        bus.REDIRECT_PC = 32'd388;
        step(1);
        bus.REDIRECT = 1'b0;
        check("t5_addr388", bus.MEM_ADDR, 32'd388);
        step(3);
        check("t5_pc396", bus.OUT_PC, 32'd396);
        check("t5_ins396", bus.OUT_INS, 32'hC0DE_0063);
        bus.OUT_READY = 1'b0;
        step(1);
        check("t5_fault", 32'(FAULT), 32'd1);
        check("t5_addr400", bus.MEM_ADDR, 32'd400);
        check("t5_still_valid", 32'(bus.OUT_VALID), 32'd1);
        check("t5_head396", bus.OUT_PC, 32'd396);
        step(1);
        check("t5_count", FETCH_COUNT, 32'd9);
        bus.OUT_READY = 1'b1;
        step(1);
        check("t5_drained", 32'(bus.OUT_VALID), 32'd0);
        check("t5_addr_hold", bus.MEM_ADDR, 32'd400);
        check("t5_fault_hold", 32'(FAULT), 32'd1);

        // 6: reset with a full queue, then EN=0 hold
        bus.OUT_READY = 1'b0;
        do_reset();
        step(2);
        check("t6_full_addr", bus.MEM_ADDR, 32'd8);
        RST_N = 1'b0;
        #1;
        check("t6_rst_comb_valid", 32'(bus.OUT_VALID), 32'd0);
        check("t6_rst_comb_addr", bus.MEM_ADDR, 32'd0);
        step(1);
        check("t6_valid", 32'(bus.OUT_VALID), 32'd0);
        check("t6_count", FETCH_COUNT, 32'd0);
        check("t6_fault", 32'(FAULT), 32'd0);
        check("t6_pc", bus.OUT_PC, 32'd0);
        EN    = 1'b0;
        RST_N = 1'b1;
        step(3);
        check("t6_en0_addr", bus.MEM_ADDR, 32'd0);
        check("t6_en0_valid", 32'(bus.OUT_VALID), 32'd0);
        check("t6_en0_count", FETCH_COUNT, 32'd0);
        EN = 1'b1;
        step(1);
        check("t6_resume_valid", 32'(bus.OUT_VALID), 32'd1);
        check("t6_resume_addr", bus.MEM_ADDR, 32'd4);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
